dot_product_feeder: RTL and testbench
=====================================

# dot_product_feeder

Front-end streamer for the 784-input dot-product engine. It accepts one (pixel, weight) pair per handshake, packs pairs into 28-lane rows and issues each row to the engine as a single-cycle strobe. After the 28th row it waits a fixed engine latency, captures the 26-bit engine result, and presents it on a valid/ready output. It sits between the pixel/weight memory reader and `DotProduct784`.

## Interface
- `LANES`, 28: lanes per row.
- `ROWS`, 28: rows per frame (784 pairs).
- `PIX_W`, 10: pixel width.
- `WGT_W`, 19: weight width, Q3.16.
- `ACC_W`, 26: engine result width, Q8.18.
- `RESULT_LAT`, 260: cycles from the last `row_valid` to a stable engine `value`.
- `clk`  in  1  single clock; all logic on the rising edge.
- `GlobalReset`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  source has a pair.
- `in_ready`  out  1  feeder accepts a pair.
- `in_pixel`  in  PIX_W  pixel.
- `in_weight`  in  WGT_W  weight.
- `row_pixels`  out  LANES*PIX_W  lane k is at `[k*PIX_W +: PIX_W]`.
- `row_weights`  out  LANES*WGT_W  lane k is at `[k*WGT_W +: WGT_W]`.
- `row_valid`  out  1  one-cycle strobe; row buses are valid.
- `frame_start`  out  1  coincides with `row_valid` of row 0; the engine clears its accumulator.
- `row_last`  out  1  coincides with `row_valid` of row ROWS-1.
- `value`  in  ACC_W  engine result.
- `result_valid`  out  1  result available.
- `result_ready`  in  1  sink accepts the result.
- `result_data`  out  ACC_W  captured result.

## Operation
- States: FILL, WAIT, DONE. Reset state is FILL.
- FILL
  - `in_ready`=1. A pair is accepted on an edge with `in_valid & in_ready`.
  - Lanes 0..LANES-2 are written into a shadow buffer indexed by `lane_cnt`.
  - On acceptance of lane LANES-1, `row_pixels`/`row_weights` load {incoming pair, shadow}. `row_valid` is 1 the next cycle. `lane_cnt` wraps to 0 and `row_cnt` increments.
  - Acceptance continues without a bubble while `row_valid` is high.
  - If the accepted lane-LANES-1 beat has `row_cnt`==ROWS-1, the next state is WAIT and `row_cnt` wraps to 0.
- WAIT
  - `in_ready`=0.
  - A down-counter is loaded with RESULT_LAT on the edge that raises the last `row_valid`, and decrements each cycle.
  - At 0, `result_data`<=`value`, `result_valid`<=1, and the state moves to DONE.
- DONE
  - `in_ready`=0. `result_valid` and `result_data` hold.
  - On `result_valid & result_ready`: `result_valid`<=0, state to FILL, `in_ready`=1 the next cycle.
- Row buses hold their last value between strobes. They are not zeroed.
- No arithmetic is done on pixel or weight data. Pixel and weight are bit-exact pass-through.
- `in_valid` is ignored while `in_ready`=0. No pair is lost or duplicated.
- Reset mid-frame discards the partial frame. The next accepted pair is lane 0 of row 0 and receives `frame_start`.

## Timing
- Reset values: `in_ready`=0, `row_valid`=0, `frame_start`=0, `row_last`=0, `result_valid`=0, `result_data`=0, row buses 0, all counters 0.
- `in_ready` is registered. It rises on the first edge after `GlobalReset` deasserts.
- `row_valid` rises 1 cycle after the edge accepting lane LANES-1.
- `result_valid` rises exactly RESULT_LAT+1 cycles after the edge accepting the final pair of the frame.
- With a continuous source, a frame occupies 784 accept cycles plus RESULT_LAT+1 cycles plus the result handshake.
- If `result_ready` is already 1 when `result_valid` rises, the handshake completes on that cycle's edge.

## Configuration
- `DOTFEED_STATS_EN` defined:
  - Adds output `frame_count[15:0]`.
  - Reset 0, +1 on each result handshake, wraps 65535->0.
- Undefined: the port and its counter are absent. All other behaviour is identical.

## Structure
- Shared package `dotfeed_pkg`:
  - state enum {FILL, WAIT, DONE}
  - LANES/ROWS/width constants
  - `lane_idx_t` and `row_idx_t` (5-bit)
  - latency counter type (9-bit)
- One sub-module, `dotfeed_row_packer`: the shadow buffer, `lane_cnt`, and the row-bus load.
- The state machine, latency counter and result register live in the top module.

## Test plan
- Reset: hold `GlobalReset`=0 for 3 cycles -> every output is 0; `in_ready`=1 one edge after release.
- Full frame, continuous `in_valid`, weight 19'h10000, pixel = i%2 -> 28 `row_valid` pulses, each row's lane k = k%2, all weights 19'h10000; `frame_start` only on row 0; `row_last` only on row 27.
- Result capture: engine model drives `value`=26'h2A5A5A5 -> `result_valid` at exactly 261 cycles after the last accept; `result_data`=26'h2A5A5A5.
- Backpressure:
  - `in_valid` toggling 1/0 -> row contents unchanged from the continuous case.
  - `result_ready` low for 10 cycles -> `result_valid`/`result_data` hold and `in_ready`=0 throughout.
- Reset after 100 accepted pairs, then a new 784-pair frame -> no stray `row_valid` before lane 27 of the new frame; the first row carries `frame_start`.
- With `DOTFEED_STATS_EN`: two complete frames -> `frame_count`=2; preload at 65535 -> one more frame gives 0.

Source files
------------

// File: rtl/dotfeed_pkg.sv
// Shared types and constants for the dot-product feeder.
package dotfeed_pkg;

  localparam int unsigned LANES      = 28;
  localparam int unsigned ROWS       = 28;
  localparam int unsigned PIX_W      = 10;
  localparam int unsigned WGT_W      = 19;
  localparam int unsigned ACC_W      = 26;
  localparam int unsigned RESULT_LAT = 260;
  localparam int unsigned IDX_W      = 5;
  localparam int unsigned LAT_W      = 9;
  localparam int unsigned FCNT_W     = 16;

  typedef enum logic [1:0] {
    FILL = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef logic [IDX_W-1:0] lane_idx_t;
  typedef logic [IDX_W-1:0] row_idx_t;
  typedef logic [LAT_W-1:0] lat_cnt_t;

  // One accepted source beat.
  typedef struct packed {
    logic [PIX_W-1:0] pixel;
    logic [WGT_W-1:0] weight;
  } pair_t;

  localparam lane_idx_t LAST_LANE = lane_idx_t'(LANES - 1);
  localparam row_idx_t  LAST_ROW  = row_idx_t'(ROWS - 1);
  localparam lat_cnt_t  LAT_LOAD  = lat_cnt_t'(RESULT_LAT);

endpackage

// File: rtl/dotfeed_row_packer.sv
// Packs accepted (pixel, weight) pairs into a LANES-wide row; lane k lands at slice k.
module dotfeed_row_packer
  import dotfeed_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     accept,
  input  pair_t                    pair,
  output logic [LANES*PIX_W-1:0]   row_pixels,
  output logic [LANES*WGT_W-1:0]   row_weights,
  output logic                     row_load_c
);

  lane_idx_t                     lane_cnt;
  logic [(LANES-1)*PIX_W-1:0]    shadow_pix;
  logic [(LANES-1)*WGT_W-1:0]    shadow_wgt;

  // The final lane of a row goes straight to the output bus alongside the shadow.
  assign row_load_c = accept && (lane_cnt == LAST_LANE);

  // Shadow capture for lanes 0..LANES-2, full-row load on the last lane.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane_cnt    <= '0;
      shadow_pix  <= '0;
      shadow_wgt  <= '0;
      row_pixels  <= '0;
      row_weights <= '0;
    end else if (accept) begin
      if (row_load_c) begin
        lane_cnt    <= '0;
        row_pixels  <= {pair.pixel, shadow_pix};
        row_weights <= {pair.weight, shadow_wgt};
      end else begin
        lane_cnt <= lane_cnt + lane_idx_t'(1);
        shadow_pix[lane_cnt*PIX_W +: PIX_W] <= pair.pixel;
        shadow_wgt[lane_cnt*WGT_W +: WGT_W] <= pair.weight;
      end
    end
  end

endmodule

// File: rtl/dot_product_feeder.sv
// Streams (pixel, weight) pairs into 28-lane rows for DotProduct784, waits the
// engine latency after the last row and returns the result on valid/ready.
// Optional DOTFEED_STATS_EN adds a 16-bit completed-frame counter output.
module dot_product_feeder
  import dotfeed_pkg::*;
(
  input  logic                     clk,
  input  logic                     GlobalReset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [PIX_W-1:0]         in_pixel,
  input  logic [WGT_W-1:0]         in_weight,
  output logic [LANES*PIX_W-1:0]   row_pixels,
  output logic [LANES*WGT_W-1:0]   row_weights,
  output logic                     row_valid,
  output logic                     frame_start,
  output logic                     row_last,
  input  logic [ACC_W-1:0]         value,
  output logic                     result_valid,
  input  logic                     result_ready,
  output logic [ACC_W-1:0]         result_data
`ifdef DOTFEED_STATS_EN
  ,
  output logic [FCNT_W-1:0]        frame_count
`endif
);

  state_t   state;
  row_idx_t row_cnt;
  lat_cnt_t lat_cnt;
  pair_t    in_pair;
  logic     accept_c;
  logic     row_load_c;

  assign in_pair  = '{pixel: in_pixel, weight: in_weight};
  assign accept_c = in_valid && in_ready;

  dotfeed_row_packer u_packer (
    .clk         (clk),
    .rst_n       (GlobalReset),
    .accept      (accept_c),
    .pair        (in_pair),
    .row_pixels  (row_pixels),
    .row_weights (row_weights),
    .row_load_c  (row_load_c)
  );

  // Frame sequencing: row strobes, engine latency wait and result handshake.
  always_ff @(posedge clk or negedge GlobalReset) begin
    if (!GlobalReset) begin
      state        <= FILL;
      in_ready     <= 1'b0;
      row_valid    <= 1'b0;
      frame_start  <= 1'b0;
      row_last     <= 1'b0;
      row_cnt      <= '0;
      lat_cnt      <= '0;
      result_valid <= 1'b0;
      result_data  <= '0;
    end else begin
      row_valid   <= row_load_c;
      frame_start <= row_load_c && (row_cnt == '0);
      row_last    <= row_load_c && (row_cnt == LAST_ROW);
      case (state)
        FILL: begin
          in_ready <= 1'b1;
          if (row_load_c) begin
            if (row_cnt == LAST_ROW) begin
              row_cnt  <= '0;
              lat_cnt  <= LAT_LOAD;
              in_ready <= 1'b0;
              state    <= WAIT;
            end else begin
              row_cnt <= row_cnt + row_idx_t'(1);
            end
          end
        end
        WAIT: begin
          in_ready <= 1'b0;
          if (lat_cnt == '0) begin
            result_data  <= value;
            result_valid <= 1'b1;
            state        <= DONE;
          end else begin
            lat_cnt <= lat_cnt - lat_cnt_t'(1);
          end
        end
        DONE: begin
          if (result_valid && result_ready) begin
            result_valid <= 1'b0;
            in_ready     <= 1'b1;
            state        <= FILL;
          end
        end
        default: begin
          state    <= FILL;
          in_ready <= 1'b0;
        end
      endcase
    end
  end

`ifdef DOTFEED_STATS_EN
  // Count completed result handshakes; wraps naturally at 16 bits.
  always_ff @(posedge clk or negedge GlobalReset) begin
    if (!GlobalReset) begin
      frame_count <= '0;
    end else if ((state == DONE) && result_valid && result_ready) begin
      frame_count <= frame_count + FCNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_dot_product_feeder.sv
// Self-checking bench for dot_product_feeder: a monitor keeps every accepted
// pair in an array and expects each 28th accept to produce a row strobe carrying
// exactly those 28 pairs; scenario tasks check reset, latency and handshakes.
module tb_dot_product_feeder;

  localparam int LANES = 28;
  localparam int NP    = 784;
  localparam int PIX_W = 10;
  localparam int WGT_W = 19;
  localparam int ACC_W = 26;
  localparam int LAT   = 260;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic                   in_valid;
  logic                   in_ready;
  logic [PIX_W-1:0]       in_pixel;
  logic [WGT_W-1:0]       in_weight;
  logic [LANES*PIX_W-1:0] row_pixels;
  logic [LANES*WGT_W-1:0] row_weights;
  logic                   row_valid;
  logic                   frame_start;
  logic                   row_last;
  logic [ACC_W-1:0]       eng_value;
  logic                   result_valid;
  logic                   result_ready;
  logic [ACC_W-1:0]       result_data;
`ifdef DOTFEED_STATS_EN
  logic [15:0]            frame_count;
`endif

  dot_product_feeder dut (
    .clk          (clk),
    .GlobalReset  (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_pixel     (in_pixel),
    .in_weight    (in_weight),
    .row_pixels   (row_pixels),
    .row_weights  (row_weights),
    .row_valid    (row_valid),
    .frame_start  (frame_start),
    .row_last     (row_last),
    .value        (eng_value),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .result_data  (result_data)
`ifdef DOTFEED_STATS_EN
    ,
    .frame_count  (frame_count)
`endif
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Source data for the current frame
  logic [PIX_W-1:0] src_pix [NP];
  logic [WGT_W-1:0] src_wgt [NP];

  // Reference model: pairs accepted in the current frame
  logic [PIX_W-1:0] mp [NP];
  logic [WGT_W-1:0] mw [NP];
  int pc = 0;
  int last_accept_cyc = 0;
  int rv_cnt = 0, fs_cnt = 0, rl_cnt = 0;
  int exp_frames = 0;

  logic [LANES*PIX_W-1:0] cont_rp, alt_rp;
  logic [LANES*WGT_W-1:0] cont_rw, alt_rw;

  // Monitor: sample handshake mid-cycle, check row outputs after the edge
  logic                   m_acc;
  logic [PIX_W-1:0]       m_pix;
  logic [WGT_W-1:0]       m_wgt;
  logic                   e_rv, e_fs, e_rl;
  logic [LANES*PIX_W-1:0] erp;
  logic [LANES*WGT_W-1:0] erw;
  initial begin
    forever begin
      @(negedge clk);
      m_acc = rst_n && in_valid && in_ready;
      m_pix = in_pixel;
      m_wgt = in_weight;
      @(posedge clk);
      #1;
      if (!rst_n) begin
        pc = 0;
        continue;
      end
      e_rv = 1'b0; e_fs = 1'b0; e_rl = 1'b0;
      if (m_acc) begin
        mp[pc] = m_pix;
        mw[pc] = m_wgt;
        pc++;
        if (pc % LANES == 0) begin
          e_rv = 1'b1;
          e_fs = (pc == LANES);
          e_rl = (pc == NP);
        end
        if (pc == NP) last_accept_cyc = cyc;
      end
      rv_cnt += int'(row_valid);
      fs_cnt += int'(frame_start);
      rl_cnt += int'(row_last);
      vectors++;
      if ({row_valid, frame_start, row_last} !== {e_rv, e_fs, e_rl}) begin
        miscompares++;
        $display("FAIL strobes at pair %0d: got rv/fs/rl=%b%b%b expected %b%b%b",
                 pc, row_valid, frame_start, row_last, e_rv, e_fs, e_rl);
      end
      if (e_rv) begin
        for (int k = 0; k < LANES; k++) begin
          erp[k*PIX_W +: PIX_W] = mp[pc-LANES+k];
          erw[k*WGT_W +: WGT_W] = mw[pc-LANES+k];
        end
        vectors++;
        if (row_pixels !== erp || row_weights !== erw) begin
          miscompares++;
          $display("FAIL row_content row %0d: got pix %h wgt %h expected pix %h wgt %h",
                   pc/LANES - 1, row_pixels, row_weights, erp, erw);
        end
      end
      if (pc == NP) pc = 0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_alt();
    for (int i = 0; i < NP; i++) begin
      src_pix[i] = PIX_W'(i % 2);
      src_wgt[i] = 19'h10000;
    end
  endtask

  task automatic fill_rand();
    for (int i = 0; i < NP; i++) begin
      src_pix[i] = PIX_W'($urandom);
      src_wgt[i] = WGT_W'($urandom);
    end
  endtask

  // Drive n pairs; mode 0 continuous, 1 toggling, 2 random gaps
  task automatic feed(input int n, input int mode, output bit to);
    int idx = 0;
    int t = 0;
    bit acc;
    while (idx < n && t < 20000) begin
      case (mode)
        0:       in_valid = 1'b1;
        1:       in_valid = (t % 2 == 0);
        default: in_valid = ($urandom % 4) != 0;
      endcase
      in_pixel  = src_pix[idx];
      in_weight = src_wgt[idx];
      acc = in_valid && in_ready;
      tick();
      t++;
      if (acc) idx++;
    end
    in_valid = 1'b0;
    to = (idx < n);
  endtask

  task automatic wait_result(output bit to);
    int n = 0;
    while (!result_valid && n < 1000) begin
      tick();
      n++;
    end
    to = !result_valid;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    vectors++;
    if ({in_ready, row_valid, frame_start, row_last, result_valid} !== 5'b0) begin
      miscompares++;
      $display("FAIL reset_flags: got %b expected 00000",
               {in_ready, row_valid, frame_start, row_last, result_valid});
    end
    vectors++;
    if (result_data !== '0 || row_pixels !== '0 || row_weights !== '0) begin
      miscompares++;
      $display("FAIL reset_buses: got data %h pix %h wgt %h expected all zero",
               result_data, row_pixels, row_weights);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    vectors++;
    if (in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL ready_before_edge: got %b expected 0", in_ready);
    end
    tick();
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL ready_after_release: got %b expected 1", in_ready);
    end
  endtask

  task automatic test_full_frame();
    bit to;
    int n = 0;
    fill_alt();
    for (int k = 0; k < LANES; k++) begin
      alt_rp[k*PIX_W +: PIX_W] = PIX_W'(k % 2);
      alt_rw[k*WGT_W +: WGT_W] = 19'h10000;
    end
    eng_value = 26'h2A5A5A5;
    result_ready = 1'b0;
    rv_cnt = 0; fs_cnt = 0; rl_cnt = 0;
    feed(NP, 0, to);
    vectors++;
    if (to) begin
      miscompares++;
      $display("FAIL full_feed_timeout: got stalled expected 784 accepts");
    end
    in_valid = 1'b1;
    while (!result_valid && n < 1000) begin
      vectors++;
      if (in_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL ready_in_wait: got %b expected 0", in_ready);
      end
      tick();
      n++;
    end
    in_valid = 1'b0;
    vectors++;
    if (!result_valid || (cyc - last_accept_cyc) != LAT + 1) begin
      miscompares++;
      $display("FAIL result_latency: got %0d (valid %b) expected %0d",
               cyc - last_accept_cyc, result_valid, LAT + 1);
    end
    vectors++;
    if (result_data !== 26'h2A5A5A5) begin
      miscompares++;
      $display("FAIL result_data: got %h expected 2a5a5a5", result_data);
    end
    vectors++;
    if (rv_cnt != 28 || fs_cnt != 1 || rl_cnt != 1) begin
      miscompares++;
      $display("FAIL strobe_counts: got rv %0d fs %0d rl %0d expected 28 1 1",
               rv_cnt, fs_cnt, rl_cnt);
    end
    vectors++;
    if (row_pixels !== alt_rp || row_weights !== alt_rw) begin
      miscompares++;
      $display("FAIL alt_pattern: got pix %h wgt %h expected pix %h wgt %h",
               row_pixels, row_weights, alt_rp, alt_rw);
    end
    cont_rp = row_pixels;
    cont_rw = row_weights;
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;
    exp_frames++;
    vectors++;
    if (result_valid !== 1'b0 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL handshake: got valid %b ready %b expected 0 1", result_valid, in_ready);
    end
  endtask

  task automatic test_in_backpressure();
    bit to, to2;
    fill_alt();
    rv_cnt = 0;
    feed(NP, 1, to);
    wait_result(to2);
    vectors++;
    if (to || to2) begin
      miscompares++;
      $display("FAIL toggle_timeout: got feed %b result %b expected 0 0", to, to2);
    end
    vectors++;
    if (row_pixels !== cont_rp || row_weights !== cont_rw || rv_cnt != 28) begin
      miscompares++;
      $display("FAIL toggle_rows: got pix %h rows %0d expected pix %h rows 28",
               row_pixels, rv_cnt, cont_rp);
    end
    vectors++;
    if ((cyc - last_accept_cyc) != LAT + 1) begin
      miscompares++;
      $display("FAIL toggle_latency: got %0d expected %0d", cyc - last_accept_cyc, LAT + 1);
    end
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;
    exp_frames++;
  endtask

  task automatic test_out_backpressure();
    bit to, to2;
    logic [ACC_W-1:0] exp_val;
    fill_rand();
    exp_val = ACC_W'($urandom);
    eng_value = exp_val;
    feed(NP, 2, to);
    wait_result(to2);
    vectors++;
    if (to || to2 || result_data !== exp_val) begin
      miscompares++;
      $display("FAIL rand_result: got %h (timeouts %b%b) expected %h", result_data, to, to2, exp_val);
    end
    eng_value = ~exp_val;
    for (int i = 0; i < 10; i++) begin
      tick();
      vectors++;
      if (result_valid !== 1'b1 || result_data !== exp_val || in_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL result_hold cycle %0d: got valid %b data %h ready %b expected 1 %h 0",
                 i, result_valid, result_data, in_ready, exp_val);
      end
    end
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;
    exp_frames++;
    vectors++;
    if (result_valid !== 1'b0 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL late_handshake: got valid %b ready %b expected 0 1", result_valid, in_ready);
    end
  endtask

  task automatic test_back_to_back();
    bit to, to2;
    logic [ACC_W-1:0] exp_val;
    result_ready = 1'b1;
    for (int f = 0; f < 2; f++) begin
      fill_rand();
      exp_val = ACC_W'($urandom);
      eng_value = exp_val;
      feed(NP, 2, to);
      wait_result(to2);
      vectors++;
      if (to || to2 || result_data !== exp_val || (cyc - last_accept_cyc) != LAT + 1) begin
        miscompares++;
        $display("FAIL b2b_result frame %0d: got %h lat %0d expected %h lat %0d",
                 f, result_data, cyc - last_accept_cyc, exp_val, LAT + 1);
      end
      tick();
      exp_frames++;
      vectors++;
      if (result_valid !== 1'b0 || in_ready !== 1'b1) begin
        miscompares++;
        $display("FAIL b2b_pulse frame %0d: got valid %b ready %b expected 0 1",
                 f, result_valid, in_ready);
      end
    end
    result_ready = 1'b0;
`ifdef DOTFEED_STATS_EN
    vectors++;
    if (frame_count !== 16'(exp_frames)) begin
      miscompares++;
      $display("FAIL frame_count: got %0d expected %0d", frame_count, exp_frames);
    end
`endif
  endtask

  task automatic test_reset_mid_frame();
    bit to, to2;
    logic [ACC_W-1:0] exp_val;
    fill_rand();
    feed(100, 2, to);
    @(negedge clk);
    rst_n = 1'b0;
    tick();
    vectors++;
    if (to || row_valid !== 1'b0 || in_ready !== 1'b0 || row_pixels !== '0 || row_weights !== '0) begin
      miscompares++;
      $display("FAIL mid_reset: got rv %b ready %b pix %h expected 0 0 0",
               row_valid, in_ready, row_pixels);
    end
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    exp_frames = 0;
    fill_rand();
    exp_val = ACC_W'($urandom);
    eng_value = exp_val;
    rv_cnt = 0; fs_cnt = 0; rl_cnt = 0;
    feed(NP, 0, to);
    wait_result(to2);
    vectors++;
    if (to || to2 || result_data !== exp_val || rv_cnt != 28 || fs_cnt != 1) begin
      miscompares++;
      $display("FAIL post_reset_frame: got data %h rows %0d fs %0d expected %h 28 1",
               result_data, rv_cnt, fs_cnt, exp_val);
    end
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;
    exp_frames++;
`ifdef DOTFEED_STATS_EN
    vectors++;
    if (frame_count !== 16'(exp_frames)) begin
      miscompares++;
      $display("FAIL frame_count_after_reset: got %0d expected %0d", frame_count, exp_frames);
    end
`endif
  endtask

  initial begin
    rst_n        = 1'b0;
    in_valid     = 1'b0;
    in_pixel     = '0;
    in_weight    = '0;
    eng_value    = '0;
    result_ready = 1'b0;
    test_reset();
    test_full_frame();
    test_in_backpressure();
    test_out_backpressure();
    test_back_to_back();
    test_reset_mid_frame();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
